// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register.
//
// The stage owns the fetch PC. It sends in-order requests to instruction
// memory over a req/gnt handshake and takes the words back on rvalid. A small
// FIFO holds words that arrive while ID is stalled. A credit rule caps
// requests in flight plus buffered words at BUF_DEPTH, so a returning word
// always has a free slot.
//
// On a flush (a redirect from pipe_ctrl):
//   - the PC jumps to target_pc,
//   - the FIFO is emptied,
//   - every response still owed by memory is marked for discard through
//     dropCnt.
// A NOP bubble (32'h0, valid=0) goes into IF/ID on a flush, or on an advance
// when no word is available.
//
// Ports
//   clock           in   1   system clock, rising edge
//   reset           in   1   asynchronous, active-low reset
//   stall           in   1   hold IF/ID contents
//   flush           in   1   squash IF/ID, redirect PC (wins over stall)
//   target_pc       in   32  redirect address, sampled while flush=1
//   imem_req        out  1   fetch request valid
//   imem_addr       out  32  fetch address (= PC)
//   imem_gnt        in   1   memory accepts the request this cycle
//   imem_rvalid     in   1   response valid, in request order
//   imem_rdata      in   32  response word
//   if_id_instr     out  32  instruction handed to ID
//   if_id_pc_plus4  out  32  address of if_id_instr + 4
//   if_id_valid     out  1   1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] target_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    // Counter width covers 0..BUF_DEPTH. The FIFO pointers need at least one bit.
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_SLOT    = PW'(BUF_DEPTH - 1);
    localparam logic [31:0]   NOP_INSTR    = 32'h0000_0000;  // sll r0,r0,0

    // One fetched word with the sequential-PC tag that travels with it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
    } fetchEntry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]   pc;           // address of the next request
    logic [31:0]   respPc;       // address of the next accepted response
    logic [CW-1:0] outstanding;  // granted requests awaiting rvalid
    logic [CW-1:0] dropCnt;      // responses still to discard after a redirect
    logic [CW-1:0] bufCount;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    fetchEntry_t   bufMem [BUF_DEPTH];

    // -----------------------------------------------------------------------
    // Per-cycle decisions
    // -----------------------------------------------------------------------
    logic          grant;
    logic          respAccept;
    logic          respDrop;
    logic          bufEmpty;
    logic          push;
    logic          pop;
    logic          bypass;
    logic [CW-1:0] inFlightNext;
    logic [31:0]   redirectPc;
    fetchEntry_t   respEntry;
    fetchEntry_t   headEntry;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PW'(1);
    endfunction

    // Credits count both words owed by memory and words already buffered.
    // While req is high and no flush arrives, the sum can only hold or fall,
    // so req and addr stay stable until the grant.
    assign imem_req  = reset && !flush &&
                       (({1'b0, outstanding} + {1'b0, bufCount}) < CREDIT_LIMIT);
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    // Word alignment is enforced on the redirect address.
    assign redirectPc = target_pc & ~32'h0000_0003;

    // NOTE: give every always_comb output a default before any branch. A path
    // that leaves an output unassigned would infer a latch.
    always_comb begin
        respAccept   = 1'b0;
        respDrop     = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        bypass       = 1'b0;
        bufEmpty     = (bufCount == '0);
        headEntry    = bufMem[rdPtr];
        respEntry    = '{instr: imem_rdata, pcPlus4: respPc + 32'd4};
        // Grant and rvalid in the same cycle cancel out.
        inFlightNext = outstanding + CW'(grant) - CW'(imem_rvalid);

        if (imem_rvalid) begin
            respDrop   = (dropCnt != '0);
            respAccept = (dropCnt == '0);
        end

        if (!flush) begin
            pop    = !stall && !bufEmpty;
            // When the buffer has entries, a new word queues behind them,
            // even while the head is popped, so order is preserved.
            push   = respAccept && (stall || !bufEmpty);
            // An empty buffer on an advance lets the word go straight to ID.
            bypass = respAccept && !stall && bufEmpty;
        end
    end

    // -----------------------------------------------------------------------
    // Control state and IF/ID register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments.
    // Every register then samples values from before the edge, regardless of
    // block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_PC;
            respPc         <= RESET_PC;
            outstanding    <= '0;
            dropCnt        <= '0;
            bufCount       <= '0;
            rdPtr          <= '0;
            wrPtr          <= '0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else begin
            outstanding <= inFlightNext;

            if (flush) begin
                // Everything still owed by memory belongs to the old path.
                // This includes a grant accepted this cycle, and it excludes
                // a response that arrives (and is ignored) this cycle.
                pc             <= redirectPc;
                respPc         <= redirectPc;
                dropCnt        <= inFlightNext;
                bufCount       <= '0;
                rdPtr          <= '0;
                wrPtr          <= '0;
                if_id_instr    <= NOP_INSTR;
                if_id_pc_plus4 <= 32'h0;
                if_id_valid    <= 1'b0;
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                if (respDrop) begin
                    dropCnt <= dropCnt - CW'(1);
                end
                if (respAccept) begin
                    respPc <= respPc + 32'd4;
                end
                if (push) begin
                    wrPtr <= nextPtr(wrPtr);
                end
                if (pop) begin
                    rdPtr <= nextPtr(rdPtr);
                end
                bufCount <= bufCount + CW'(push) - CW'(pop);

                if (!stall) begin
                    if (pop) begin
                        if_id_instr    <= headEntry.instr;
                        if_id_pc_plus4 <= headEntry.pcPlus4;
                        if_id_valid    <= 1'b1;
                    end else if (bypass) begin
                        if_id_instr    <= respEntry.instr;
                        if_id_pc_plus4 <= respEntry.pcPlus4;
                        if_id_valid    <= 1'b1;
                    end else begin
                        if_id_instr    <= NOP_INSTR;
                        if_id_pc_plus4 <= 32'h0;
                        if_id_valid    <= 1'b0;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Buffer storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. Entries are only read after they
    // are written, and bufCount/pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            bufMem[wrPtr] <= respEntry;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Directed bench for if_stage, built with RESET_PC=0x100 and BUF_DEPTH=2.
//
// The memory responder:
//   - records each grant just before the rising edge,
//   - returns the granted address as the data word one cycle later,
//     when respEn is set.
//
// Stimulus changes just after the falling edge. Outputs are checked there
// too, away from the active edge.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] target_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    logic        respEn;
    logic [31:0] pendQ[$];
    logic [64:0] got;
    logic [64:0] exp;

    if_stage #(
        .RESET_PC (32'h0000_0100),
        .BUF_DEPTH(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .target_pc     (target_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory responder: words come back in grant order.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (reset && respEn && pendQ.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pendQ[0];
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            @(negedge clock);
            #4;
            if (!reset) begin
                pendQ.delete();
            end else begin
                if (imem_rvalid) begin
                    void'(pendQ.pop_front());
                end
                if (imem_req && imem_gnt) begin
                    pendQ.push_back(imem_addr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset     = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        imem_gnt  = 1'b0;
        respEn    = 1'b1;
        target_pc = 32'h0;
        step();
        step();
        reset = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        // gnt=1 and no credit use: req would be 1 but for reset.
        imem_gnt = 1'b1;
        step();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if (imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 00000100", imem_addr);
        end
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b0, 32'h0, 32'h0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_ifid: got %h expected %h", got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stream();
        do_reset();
        imem_gnt = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000100",
                     imem_req, imem_addr);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h104) begin
            errors++;
            $display("FAIL stream_latency: got valid=%b addr=%h expected valid=0 addr=00000104",
                     if_id_valid, imem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            got = {if_id_valid, if_id_instr, if_id_pc_plus4};
            exp = {1'b1, 32'h100 + 32'(4 * k), 32'h104 + 32'(4 * k)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stream_word%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Continues from test_stream. IF/ID holds 0x110 and 0x114 is in flight.
    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 3) begin
                stall = 1'b0;
                #1;
            end
            got = {if_id_valid, if_id_instr, if_id_pc_plus4};
            exp = {1'b1, 32'h110, 32'h114};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h expected %h", k, got, exp);
            end
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_credit%0d: got req=%b expected 0", k, imem_req);
            end
        end
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h114, 32'h118};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_release0: got %h expected %h", got, exp);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h11c) begin
            errors++;
            $display("FAIL stall_resume_req: got req=%b addr=%h expected req=1 addr=0000011c",
                     imem_req, imem_addr);
        end
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h118, 32'h11c};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_release1: got %h expected %h", got, exp);
        end
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h11c, 32'h120};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stall_release2: got %h expected %h", got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_flush();
        do_reset();
        imem_gnt = 1'b1;
        respEn   = 1'b0;
        step();
        step();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre_credit: got req=%b expected 0", imem_req);
        end
        // Two requests (0x100, 0x104) are outstanding. The low target bits are ignored.
        flush     = 1'b1;
        target_pc = 32'h203;
        respEn    = 1'b1;
        step();
        flush = 1'b0;
        #1;
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b0, 32'h0, 32'h0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flush_bubble0: got %h expected %h", got, exp);
        end
        step();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL flush_redirect_req: got req=%b addr=%h expected req=1 addr=00000200",
                     imem_req, imem_addr);
        end
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop0: got valid=%b instr=%h expected valid=0",
                     if_id_valid, if_id_instr);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop1: got valid=%b instr=%h expected valid=0",
                     if_id_valid, if_id_instr);
        end
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h200, 32'h204};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flush_first_word: got %h expected %h", got, exp);
        end
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h204, 32'h208};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flush_second_word: got %h expected %h", got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Continues from test_flush. IF/ID holds 0x204, 0x208 returns this cycle,
    // and req for 0x20c is pending.
    task automatic test_flush_stall();
        flush     = 1'b1;
        stall     = 1'b1;
        target_pc = 32'h300;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flushstall_req: got req=%b expected 0", imem_req);
        end
        step();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b0, 32'h0, 32'h0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flushstall_bubble: got %h expected %h", got, exp);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL flushstall_pc: got req=%b addr=%h expected req=1 addr=00000300",
                     imem_req, imem_addr);
        end
        step();
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h300, 32'h304};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL flushstall_word: got %h expected %h", got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_no_grant();
        do_reset();
        imem_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                errors++;
                $display("FAIL nogrant_req%0d: got req=%b addr=%h expected req=1 addr=00000100",
                         k, imem_req, imem_addr);
            end
            checks++;
            if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
                errors++;
                $display("FAIL nogrant_ifid%0d: got valid=%b instr=%h expected valid=0 instr=0",
                         k, if_id_valid, if_id_instr);
            end
        end
        imem_gnt = 1'b1;
        step();
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h100, 32'h104};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL nogrant_first_word: got %h expected %h", got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Continues from test_no_grant. IF/ID holds 0x100 and 0x104 returns this cycle.
    task automatic test_reset_mid();
        respEn = 1'b0;
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h104, 32'h108};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rstmid_pre_word: got %h expected %h", got, exp);
        end
        step();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_two_outstanding: got req=%b expected 0", imem_req);
        end
        // Asserted between clock edges: outputs must clear with no edge.
        reset = 1'b0;
        #1;
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b0, 32'h0, 32'h0};
        checks++;
        if (got !== exp || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rstmid_async: got ifid=%h req=%b addr=%h expected ifid=%h req=0 addr=00000100",
                     got, imem_req, imem_addr, exp);
        end
        step();
        step();
        reset  = 1'b1;
        respEn = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL rstmid_restart_req: got req=%b addr=%h expected req=1 addr=00000100",
                     imem_req, imem_addr);
        end
        step();
        step();
        got = {if_id_valid, if_id_instr, if_id_pc_plus4};
        exp = {1'b1, 32'h100, 32'h104};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rstmid_restart_word: got %h expected %h", got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        target_pc = 32'h0;
        imem_gnt  = 1'b0;
        respEn    = 1'b1;

        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_stall();
        test_no_grant();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
